// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key-schedule controller and its key store.
package aes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFeed,
    StCollect,
    StReady
  } sched_state_e;

  localparam int unsigned TimeoutDefault = 64;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Number of cipher rounds for a given key size; unknown sizes fall back to AES-128.
  function automatic int unsigned nr_of(input int unsigned mode);
    if (mode == 256) return 14;
    if (mode == 192) return 12;
    return 10;
  endfunction

endpackage

// File: rtl/aes_key_store.sv
// Round-key store: single write port, registered read port, per-entry valid bitmap.
module aes_key_store #(
  parameter int unsigned Depth = 11,
  parameter int unsigned Width = 128,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic             rd_valid,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem_q [Depth];
  logic [Depth-1:0] valid_q;
  logic             rd_valid_q;
  logic [Width-1:0] rd_data_q;
  logic             rd_hit;

  assign rd_hit = rd_en && (32'(rd_addr) < Depth) && valid_q[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A clear in the same cycle as a read still returns the old entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_data_q  <= rd_hit ? mem_q[rd_addr] : '0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key-schedule sequencer: loads the cipher key, drives round_key_gen, captures every
// round key into a local store and serves indexed reads (any order) once complete.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 128,
  parameter int unsigned MODE      = 128,
  parameter int unsigned TIMEOUT   = TimeoutDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 key_valid,
  output logic                 key_ready_o,
  input  logic [BUS_WIDTH-1:0] key_beat,
  output logic                 gen_dv,
  output logic [BUS_WIDTH-1:0] gen_cipher_key,
  output logic                 gen_round_key_needed,
  input  logic [3:0]           gen_rcon_address,
  output logic [7:0]           gen_next_rcon,
  input  logic [BUS_WIDTH-1:0] gen_rkey,
  input  logic                 gen_key_ready,
  input  logic                 rk_req,
  input  logic [3:0]           rk_round,
  output logic                 rk_valid,
  output logic [BUS_WIDTH-1:0] rk_data,
  output logic                 rk_err,
  output logic                 busy,
  output logic                 sched_done,
  output logic                 sched_err
);

  localparam int unsigned NR    = nr_of(MODE);
  localparam int unsigned BEATS = MODE / BUS_WIDTH;
  localparam int unsigned CntW  = $clog2(BEATS + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  sched_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      k_q, k_d;
  logic            wait_q, wait_d;
  logic [ToW-1:0]  to_q, to_d;
  logic [MODE-1:0] key_q;
  logic            rk_err_q;

  logic capture, last_key, timeout, load_entry, rd_en;

  assign capture    = (state_q == StCollect) && gen_key_ready && !wait_q;
  assign last_key   = (k_q == 4'(NR));
  // Capture has priority over an expiring timeout in the same cycle.
  assign timeout    = (state_q == StCollect) && !capture && (to_q == ToW'(TIMEOUT - 1));
  assign load_entry = start && ((state_q == StIdle) || (state_q == StReady));
  assign rd_en      = rk_req && (state_q == StReady) && (rk_round <= 4'(NR));

  assign gen_next_rcon = (gen_rcon_address < 4'd10) ? RCON[gen_rcon_address] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
      wait_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
    end
  end

  // Beat 0 is the most significant slice of the key.
  always_ff @(posedge clk) begin
    if ((state_q == StLoad) && key_valid) begin
      key_q[(BEATS - 1 - int'(cnt_q)) * BUS_WIDTH +: BUS_WIDTH] <= key_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_err_q <= 1'b0;
    end else begin
      rk_err_q <= rk_req && !rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    wait_d  = wait_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (key_valid) begin
          if (cnt_q == CntW'(BEATS - 1)) begin
            state_d = StFeed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFeed: begin
        if (cnt_q == CntW'(BEATS)) begin
          state_d = StCollect;
          cnt_d   = '0;
          k_d     = '0;
          wait_d  = 1'b0;
          to_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCollect: begin
        if (capture) begin
          to_d = '0;
          k_d  = k_q + 1'b1;
          if (last_key) begin
            state_d = StReady;
          end else begin
            wait_d = 1'b1;
          end
        end else begin
          // A held gen_key_ready must drop before the next key can be taken.
          if (!gen_key_ready) wait_d = 1'b0;
          if (timeout) begin
            state_d = StIdle;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    key_ready_o          = 1'b0;
    busy                 = 1'b0;
    gen_dv               = 1'b0;
    gen_cipher_key       = '0;
    gen_round_key_needed = 1'b0;
    sched_done           = 1'b0;
    sched_err            = 1'b0;
    unique case (state_q)
      StLoad: begin
        key_ready_o = 1'b1;
        busy        = 1'b1;
      end
      StFeed: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          gen_dv = 1'b1;
        end else begin
          gen_cipher_key = key_q[(BEATS - int'(cnt_q)) * BUS_WIDTH +: BUS_WIDTH];
        end
      end
      StCollect: begin
        busy                 = 1'b1;
        gen_round_key_needed = capture && !last_key;
        sched_done           = capture && last_key;
        sched_err            = timeout;
      end
      default: ;
    endcase
  end

  aes_key_store #(
    .Depth (NR + 1),
    .Width (BUS_WIDTH),
    .AddrW (4)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_entry || timeout),
    .wr_en    (capture),
    .wr_addr  (k_q),
    .wr_data  (gen_rkey),
    .rd_en    (rd_en),
    .rd_addr  (rk_round),
    .rd_valid (rk_valid),
    .rd_data  (rk_data)
  );

  assign rk_err = rk_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl (AES-128, single 128-bit beat) with a
// round_key_gen stand-in that replays the FIPS-197 A.1 key expansion.
module tb_aes_key_sched_ctrl;

  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst, start, key_valid, key_ready_o;
  logic [127:0] key_beat, gen_cipher_key, gen_rkey, rk_data;
  logic         gen_dv, gen_round_key_needed, gen_key_ready;
  logic [3:0]   gen_rcon_address, rk_round;
  logic [7:0]   gen_next_rcon;
  logic         rk_req, rk_valid, rk_err, busy, sched_done, sched_err;

  int checks   = 0;
  int failures = 0;
  int acks, dones, n;
  logic found;

  logic [127:0] rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [7:0] rcon_exp [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(
    .BUS_WIDTH (128),
    .MODE      (128),
    .TIMEOUT   (TO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .key_valid            (key_valid),
    .key_ready_o          (key_ready_o),
    .key_beat             (key_beat),
    .gen_dv               (gen_dv),
    .gen_cipher_key       (gen_cipher_key),
    .gen_round_key_needed (gen_round_key_needed),
    .gen_rcon_address     (gen_rcon_address),
    .gen_next_rcon        (gen_next_rcon),
    .gen_rkey             (gen_rkey),
    .gen_key_ready        (gen_key_ready),
    .rk_req               (rk_req),
    .rk_round             (rk_round),
    .rk_valid             (rk_valid),
    .rk_data              (rk_data),
    .rk_err               (rk_err),
    .busy                 (busy),
    .sched_done           (sched_done),
    .sched_err            (sched_err)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic act, input logic exp);
    chk(tag, {127'b0, act}, {127'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered one step after the LOAD edge; leaves one step into COLLECT's second cycle.
  task automatic load_feed(input logic [127:0] key);
    key_valid = 1'b1;
    key_beat  = key;
    @(negedge clk);
    chk1("load_ready", key_ready_o, 1'b1);
    tick();
    key_valid = 1'b0;
    key_beat  = '0;
    @(negedge clk);
    chk1("feed_dv", gen_dv, 1'b1);
    tick();
    @(negedge clk);
    chk("feed_key", gen_cipher_key, key);
    chk1("feed_dv_low", gen_dv, 1'b0);
    tick();
    @(negedge clk);
    chk("collect_key_idle", gen_cipher_key, 128'h0);
    tick();
  endtask

  // Generator stand-in: presents key i with gen_key_ready high for `hold` cycles, then low.
  task automatic serve(input int nkeys, input int hold, output int a, output int d);
    a = 0;
    d = 0;
    for (int i = 0; i < nkeys; i++) begin
      gen_rkey      = rk[i];
      gen_key_ready = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        a += int'(gen_round_key_needed);
        d += int'(sched_done);
        tick();
      end
      gen_key_ready = 1'b0;
      @(negedge clk);
      a += int'(gen_round_key_needed);
      d += int'(sched_done);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_beat = '0;
    gen_rcon_address = 4'd0; gen_rkey = '0; gen_key_ready = 1'b0;
    rk_req = 1'b0; rk_round = 4'd0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_ctl", 128'({busy, key_ready_o, gen_dv, gen_round_key_needed,
                           rk_valid, rk_err, sched_done, sched_err}), 128'h0);
    chk("reset_cipher_key", gen_cipher_key, 128'h0);
    chk("reset_rk_data", rk_data, 128'h0);
    for (int i = 0; i < 16; i++) begin
      gen_rcon_address = 4'(i);
      #1;
      chk("rcon", 128'(gen_next_rcon), 128'(rcon_exp[i]));
    end
    gen_rcon_address = 4'd0;
    tick();
    rst = 1'b0;
    tick();

    // Full schedule, gen_key_ready high one cycle per key.
    do_start();
    load_feed(rk[0]);
    serve(11, 1, acks, dones);
    chk("acks_hold1", 128'(acks), 128'(10));
    chk("done_hold1", 128'(dones), 128'(1));
    @(negedge clk);
    chk1("ready_not_busy", busy, 1'b0);
    tick();

    // Last-round-first reads, back-to-back.
    rk_req   = 1'b1;
    rk_round = 4'd10;
    for (int r = 10; r >= 0; r--) begin
      tick();
      if (r > 0) rk_round = 4'(r - 1);
      else rk_req = 1'b0;
      @(negedge clk);
      chk1("rd_valid", rk_valid, 1'b1);
      chk("rd_data", rk_data, rk[r]);
    end
    tick();

    rk_req   = 1'b1;
    rk_round = 4'd11;
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk1("err_round11", rk_err, 1'b1);
    chk1("err_round11_valid", rk_valid, 1'b0);
    chk("err_round11_data", rk_data, 128'h0);
    tick();

    // Restart with a same-cycle read: served from the old contents.
    start    = 1'b1;
    rk_req   = 1'b1;
    rk_round = 4'd0;
    tick();
    start  = 1'b0;
    rk_req = 1'b0;
    @(negedge clk);
    chk1("restart_rd_valid", rk_valid, 1'b1);
    chk("restart_rd_data", rk_data, rk[0]);
    tick();
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk1("err_in_load", rk_err, 1'b1);
    tick();

    // Held gen_key_ready: one capture and one ack per key.
    load_feed(rk[0]);
    serve(11, 5, acks, dones);
    chk("acks_hold5", 128'(acks), 128'(10));
    chk("done_hold5", 128'(dones), 128'(1));
    rk_req   = 1'b1;
    rk_round = 4'd5;
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk("hold5_rd5", rk_data, rk[5]);
    tick();

    // Generator stalls after key 3: timeout.
    do_start();
    load_feed(rk[0]);
    serve(4, 1, acks, dones);
    chk("acks_stall", 128'(acks), 128'(4));
    n     = 2;
    found = 1'b0;
    while (!found && n < int'(TO) + 10) begin
      @(negedge clk);
      if (sched_err) begin
        found = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    chk1("timeout_seen", found, 1'b1);
    chk1("timeout_cycle", (n >= int'(TO) - 1) && (n <= int'(TO) + 1), 1'b1);
    tick();
    @(negedge clk);
    chk1("timeout_idle_busy", busy, 1'b0);
    chk1("timeout_pulse", sched_err, 1'b0);
    tick();
    rk_req   = 1'b1;
    rk_round = 4'd3;
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk1("err_in_idle", rk_err, 1'b1);
    chk1("err_in_idle_valid", rk_valid, 1'b0);
    tick();

    // Reset at k = 5 with the generator still offering a key.
    do_start();
    load_feed(rk[0]);
    serve(5, 1, acks, dones);
    rst           = 1'b1;
    gen_key_ready = 1'b1;
    gen_rkey      = rk[5];
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", 128'({busy, key_ready_o, gen_dv, gen_round_key_needed,
                            rk_valid, rk_err, sched_done, sched_err}), 128'h0);
    chk("midrst_cipher_key", gen_cipher_key, 128'h0);
    tick();
    gen_key_ready = 1'b0;
    do_start();
    load_feed(rk[0]);
    serve(11, 1, acks, dones);
    chk("acks_after_rst", 128'(acks), 128'(10));
    chk("done_after_rst", 128'(dones), 128'(1));
    rk_req   = 1'b1;
    rk_round = 4'd10;
    tick();
    rk_round = 4'd0;
    @(negedge clk);
    chk("after_rst_rd10", rk_data, rk[10]);
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk("after_rst_rd0", rk_data, rk[0]);
    chk1("after_rst_rd0_valid", rk_valid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
